// File: rtl/voxel_pkg.sv
// -----------------------------------------------------------------------------
// voxel_pkg
// Shared constants and types for the rotating-LED display slice.
//   GLB_WIDTH     : column slices per revolution (power of two)
//   GLB_FPS       : nominal revolutions per second of the rotor
//   STALL_FPS     : slowest rotation still treated as spinning
//   CLK_10M_FREQ  : system clock frequency in Hz
//   sched_state_t : slice scheduler states
//   slice_idx_t   : slice / column index at the default GLB_WIDTH
// -----------------------------------------------------------------------------
package voxel_pkg;

  localparam int unsigned GLB_WIDTH    = 128;
  localparam int unsigned GLB_FPS      = 30;
  localparam int unsigned STALL_FPS    = 5;
  localparam int unsigned CLK_10M_FREQ = 10_000_000;
  localparam int unsigned SLICE_IDX_W  = $clog2(GLB_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } sched_state_t;

  typedef logic [SLICE_IDX_W-1:0] slice_idx_t;

  // Clock cycles in one revolution at the given revolutions per second.
  function automatic int unsigned revPeriodCycles(input int unsigned revPerSec);
    return CLK_10M_FREQ / revPerSec;
  endfunction

endpackage

// File: rtl/mag_edge_sync.sv
// -----------------------------------------------------------------------------
// mag_edge_sync
// Brings the asynchronous MAG2 magnet pulse into CLK_10M, detects its rising
// edge and suppresses edges that arrive too soon after the last accepted one.
// Ports:
//   CLK_10M      in  system clock
//   nReset       in  synchronous active-low reset
//   MAG2         in  raw magnet sensor
//   isIdle       in  scheduler is IDLE (holdoff does not apply)
//   cycSinceEdge in  cycles since the last accepted edge
//   acceptedEdge out one-cycle pulse, 3 clock edges after MAG2 is first sampled high
// -----------------------------------------------------------------------------
module mag_edge_sync #(
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned MIN_PERIOD = voxel_pkg::revPeriodCycles(voxel_pkg::GLB_FPS)
) (
  input  logic                CLK_10M,
  input  logic                nReset,
  input  logic                MAG2,
  input  logic                isIdle,
  input  logic [PERIOD_W-1:0] cycSinceEdge,
  output logic                acceptedEdge
);

  localparam logic [PERIOD_W-1:0] HOLDOFF = PERIOD_W'(MIN_PERIOD);

  // [0],[1]: metastability synchronizer; [2]: previous synchronized level
  logic [2:0] magSync;
  logic       magRise;
  logic       holdoffDone;

  assign magRise     = magSync[1] & ~magSync[2];
  assign holdoffDone = isIdle | (cycSinceEdge >= HOLDOFF);

  // Synchronizer, edge detect and holdoff gate
  always_ff @(posedge CLK_10M) begin
    if (!nReset) begin
      magSync      <= '0;
      acceptedEdge <= 1'b0;
    end else begin
      magSync      <= {magSync[1:0], MAG2};
      acceptedEdge <= magRise & holdoffDone;
    end
  end

endmodule

// File: rtl/slice_scheduler.sv
// -----------------------------------------------------------------------------
// slice_scheduler
// Measures the rotor period from the once-per-revolution MAG2 pulse and emits
// GLB_WIDTH evenly spaced slice strobes per revolution, each raising a column
// fetch request towards the LED fetch/shift engine. Flags stall and overrun.
// Ports:
//   CLK_10M     in  system clock, 10 MHz
//   nReset      in  synchronous active-low reset
//   MAG2        in  raw magnet sensor pulse
//   sliceStrobe out one-cycle pulse at each slice boundary
//   sliceIndex  out current slice
//   fetchReq    out column fetch request, held until fetchAck
//   fetchIndex  out column to fetch, valid while fetchReq
//   fetchAck    in  fetch engine accepted the request
//   locked      out period measured and slices running
//   stalled     out sticky: rotor timed out; cleared by next accepted edge
//   overrun     out sticky: strobe while a fetch was still pending
//   period      out last measured revolution period in cycles
// -----------------------------------------------------------------------------
module slice_scheduler #(
  parameter int unsigned GLB_WIDTH  = voxel_pkg::GLB_WIDTH,
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned MIN_PERIOD = voxel_pkg::revPeriodCycles(voxel_pkg::GLB_FPS),
  parameter int unsigned MAX_PERIOD = voxel_pkg::revPeriodCycles(voxel_pkg::STALL_FPS)
) (
  input  logic                         CLK_10M,
  input  logic                         nReset,
  input  logic                         MAG2,
  output logic                         sliceStrobe,
  output logic [$clog2(GLB_WIDTH)-1:0] sliceIndex,
  output logic                         fetchReq,
  output logic [$clog2(GLB_WIDTH)-1:0] fetchIndex,
  input  logic                         fetchAck,
  output logic                         locked,
  output logic                         stalled,
  output logic                         overrun,
  output logic [PERIOD_W-1:0]          period
);

  import voxel_pkg::*;

  localparam int unsigned IDX_W = $clog2(GLB_WIDTH);
  // Phase accumulator holds t*GLB_WIDTH and bounds hold k*period: never wraps
  localparam int unsigned ACC_W = PERIOD_W + IDX_W;

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(GLB_WIDTH - 1);
  localparam logic [PERIOD_W-1:0] MAX_CNT  = PERIOD_W'(MAX_PERIOD);
  localparam logic [ACC_W-1:0]    ACC_STEP = ACC_W'(GLB_WIDTH);

  sched_state_t        state;
  logic                acceptedEdge;
  logic [PERIOD_W-1:0] cycSinceEdge;
  logic [PERIOD_W-1:0] newPeriod;
  logic [ACC_W-1:0]    phaseAcc;
  logic [ACC_W-1:0]    nextBound;
  logic                timeout;
  logic                sliceHit;

  mag_edge_sync #(
    .PERIOD_W   (PERIOD_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) uMagEdge (
    .CLK_10M      (CLK_10M),
    .nReset       (nReset),
    .MAG2         (MAG2),
    .isIdle       (state == IDLE),
    .cycSinceEdge (cycSinceEdge),
    .acceptedEdge (acceptedEdge)
  );

  // Edge-to-edge distance is the counter value plus the edge cycle itself
  assign newPeriod = cycSinceEdge + PERIOD_W'(1);
  assign timeout   = (state != IDLE) && (cycSinceEdge == MAX_CNT);

  // phaseAcc already holds (t+1)*GLB_WIDTH, so a hit here makes the registered
  // strobe appear on the first cycle t with t*GLB_WIDTH >= k*period
  assign sliceHit  = (state == RUN) && (sliceIndex != LAST_IDX) && (phaseAcc >= nextBound);

  // Cycles since the last accepted edge, saturating at the stall timeout
  always_ff @(posedge CLK_10M) begin
    if (!nReset) begin
      cycSinceEdge <= '0;
    end else if (acceptedEdge) begin
      cycSinceEdge <= '0;
    end else if (cycSinceEdge != MAX_CNT) begin
      cycSinceEdge <= cycSinceEdge + PERIOD_W'(1);
    end
  end

  // Scheduler FSM, slice timing and fetch handshake
  always_ff @(posedge CLK_10M) begin
    if (!nReset) begin
      state       <= IDLE;
      sliceStrobe <= 1'b0;
      sliceIndex  <= '0;
      phaseAcc    <= '0;
      nextBound   <= '0;
      locked      <= 1'b0;
      stalled     <= 1'b0;
      period      <= '0;
      fetchReq    <= 1'b0;
      fetchIndex  <= '0;
      overrun     <= 1'b0;
    end else begin
      sliceStrobe <= 1'b0;

      if (acceptedEdge) begin
        stalled <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (acceptedEdge) begin
            state <= MEASURE;
          end
        end

        MEASURE, RUN: begin
          // An edge beats both a pending slice boundary and the timeout
          if (acceptedEdge) begin
            state       <= RUN;
            period      <= newPeriod;
            locked      <= 1'b1;
            sliceStrobe <= 1'b1;
            sliceIndex  <= '0;
            phaseAcc    <= ACC_STEP;
            nextBound   <= ACC_W'(newPeriod);
          end else if (timeout) begin
            state   <= IDLE;
            locked  <= 1'b0;
            stalled <= 1'b1;
          end else if (state == RUN) begin
            // Once the last slice is out, hold until the next edge
            if (sliceIndex != LAST_IDX) begin
              phaseAcc <= phaseAcc + ACC_STEP;
            end
            if (sliceHit) begin
              sliceStrobe <= 1'b1;
              sliceIndex  <= sliceIndex + IDX_W'(1);
              nextBound   <= nextBound + ACC_W'(period);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // A newer strobe replaces any pending column; the stale one is dropped
      if (timeout && !acceptedEdge) begin
        fetchReq <= 1'b0;
      end else if (sliceStrobe) begin
        fetchReq   <= 1'b1;
        fetchIndex <= sliceIndex;
        if (fetchReq && !fetchAck) begin
          overrun <= 1'b1;
        end
      end else if (fetchAck) begin
        fetchReq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_slice_scheduler
// Self-checking bench for slice_scheduler with MIN_PERIOD=100, MAX_PERIOD=5000,
// GLB_WIDTH=128. A table of MAG2 pulse gaps drives the main sequence; expected
// slice strobes (index, offset from slice 0) are queued when pulses are driven
// and popped as the DUT strobes. Hand-written sequences cover stall, relock,
// fetch overrun and mid-revolution reset.
// -----------------------------------------------------------------------------
module tb_slice_scheduler;

  localparam int unsigned GW = 128;
  localparam int unsigned PW = 24;
  localparam int unsigned IW = 7;
  localparam int NROWS = 7;

  logic          CLK_10M = 1'b0;
  logic          nReset;
  logic          MAG2;
  logic          sliceStrobe;
  logic [IW-1:0] sliceIndex;
  logic          fetchReq;
  logic [IW-1:0] fetchIndex;
  logic          fetchAck;
  logic          locked;
  logic          stalled;
  logic          overrun;
  logic [PW-1:0] period;

  slice_scheduler #(
    .GLB_WIDTH  (GW),
    .PERIOD_W   (PW),
    .MIN_PERIOD (100),
    .MAX_PERIOD (5000)
  ) dut (
    .CLK_10M     (CLK_10M),
    .nReset      (nReset),
    .MAG2        (MAG2),
    .sliceStrobe (sliceStrobe),
    .sliceIndex  (sliceIndex),
    .fetchReq    (fetchReq),
    .fetchIndex  (fetchIndex),
    .fetchAck    (fetchAck),
    .locked      (locked),
    .stalled     (stalled),
    .overrun     (overrun),
    .period      (period)
  );

  always #50 CLK_10M = ~CLK_10M;

  typedef struct {
    int unsigned idx;
    int unsigned off;
  } exp_t;

  typedef struct {
    int unsigned gap;        // cycles from previous pulse start
    bit          restart;    // pulse accepted in MEASURE/RUN -> slice 0
    bit          expLocked;
    int unsigned expPeriod;
  } vec_t;

  exp_t        expQ[$];
  vec_t        vecs[NROWS];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lastBase = 0;
  int          pulseCyc = 0;
  int unsigned lastExpIdx = 0;
  bit          autoAck = 1'b1;
  logic        prevReq = 1'b0;
  int unsigned nextGap;
  int unsigned accGap;
  bit          found;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic checkRange(input string name, input longint got, input longint lo, input longint hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, got, lo, hi, cyc);
    end
  endtask

  // One clock: advance, then observe on the falling edge and drive inputs
  task automatic tick();
    exp_t e;
    @(posedge CLK_10M);
    cyc++;
    @(negedge CLK_10M);
    if (nReset) begin
      if (sliceStrobe) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got index %0d expected no strobe (cycle %0d)", sliceIndex, cyc);
        end else begin
          e = expQ.pop_front();
          if (e.idx == 0) lastBase = cyc;
          check("strobe_index", sliceIndex, e.idx);
          check("strobe_offset", cyc - lastBase, e.off);
          lastExpIdx = e.idx;
        end
      end
      if (fetchReq && !prevReq) check("fetch_index", fetchIndex, lastExpIdx);
      prevReq = fetchReq;
      if (autoAck) fetchAck = fetchReq && !fetchAck;
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse();
    pulseCyc = cyc;
    MAG2 = 1'b1;
    repeat (3) tick();
    MAG2 = 1'b0;
  endtask

  // Slice k of a revolution of period p lands at ceil(k*p/GW); only the ones
  // before the next accepted edge (at offset limit) are emitted
  task automatic pushRev(input int unsigned p, input int unsigned limit);
    int unsigned off;
    for (int unsigned k = 0; k < GW; k++) begin
      off = (k * p + GW - 1) / GW;
      if (off < limit) expQ.push_back('{idx: k, off: off});
    end
  endtask

  initial begin
    nReset   = 1'b0;
    MAG2     = 1'b0;
    fetchAck = 1'b0;

    vecs[0] = '{gap: 0,    restart: 1'b0, expLocked: 1'b0, expPeriod: 0};
    vecs[1] = '{gap: 1280, restart: 1'b1, expLocked: 1'b1, expPeriod: 1280};
    vecs[2] = '{gap: 1280, restart: 1'b1, expLocked: 1'b1, expPeriod: 1280};
    vecs[3] = '{gap: 1000, restart: 1'b1, expLocked: 1'b1, expPeriod: 1000};
    vecs[4] = '{gap: 1280, restart: 1'b1, expLocked: 1'b1, expPeriod: 1280};
    vecs[5] = '{gap: 50,   restart: 1'b0, expLocked: 1'b1, expPeriod: 1280};
    vecs[6] = '{gap: 590,  restart: 1'b1, expLocked: 1'b1, expPeriod: 640};

    repeat (3) tick();
    check("rst_sliceStrobe", sliceStrobe, 0);
    check("rst_sliceIndex", sliceIndex, 0);
    check("rst_fetchReq", fetchReq, 0);
    check("rst_fetchIndex", fetchIndex, 0);
    check("rst_locked", locked, 0);
    check("rst_stalled", stalled, 0);
    check("rst_overrun", overrun, 0);
    check("rst_period", period, 0);
    nReset = 1'b1;
    repeat (5) tick();

    // Table-driven pulse sequence: lock, steady, non-integer spacing,
    // slow-down, glitch holdoff, speed-up
    for (int r = 0; r < NROWS; r++) begin
      if (r > 0) waitUntil(pulseCyc + int'(vecs[r].gap));
      if (vecs[r].restart) begin
        nextGap = 32'h4000_0000;
        accGap  = 0;
        found   = 1'b0;
        for (int j = r + 1; j < NROWS; j++) begin
          accGap += vecs[j].gap;
          if (vecs[j].restart && !found) begin
            nextGap = accGap;
            found   = 1'b1;
          end
        end
        pushRev(vecs[r].expPeriod, nextGap);
      end
      pulse();
      repeat (8) tick();
      check("row_period", period, vecs[r].expPeriod);
      check("row_locked", locked, vecs[r].expLocked);
      if (vecs[r].restart) checkRange("slice0_latency", lastBase - pulseCyc, 1, 8);
      else                 check("no_restart", lastBase < pulseCyc, 1);
    end

    // Stall: no more pulses, expect timeout about MAX_PERIOD after last edge
    while (locked && cyc < pulseCyc + 6000) tick();
    checkRange("timeout_latency", cyc - pulseCyc, 5000, 5010);
    check("stall_locked", locked, 0);
    check("stall_stalled", stalled, 1);
    check("stall_fetchReq", fetchReq, 0);
    check("stall_period_kept", period, 640);
    check("stall_queue_drained", expQ.size(), 0);
    check("auto_ack_overrun", overrun, 0);
    repeat (20) tick();
    check("stall_sticky", stalled, 1);

    // Relock with two edges
    pulse();
    repeat (8) tick();
    check("relock1_locked", locked, 0);
    waitUntil(pulseCyc + 1280);
    pushRev(1280, 32'h4000_0000);
    pulse();
    repeat (8) tick();
    check("relock2_locked", locked, 1);
    check("relock2_stalled", stalled, 0);
    check("relock2_period", period, 1280);
    waitUntil(pulseCyc + 1300);
    check("relock_queue_drained", expQ.size(), 0);

    // Fetch overrun with fetchAck held low
    nReset = 1'b0;
    expQ.delete();
    autoAck  = 1'b0;
    fetchAck = 1'b0;
    repeat (2) tick();
    nReset  = 1'b1;
    prevReq = 1'b0;
    repeat (3) tick();
    pulse();
    repeat (8) tick();
    waitUntil(pulseCyc + 1280);
    pushRev(1280, 32'h4000_0000);
    pulse();
    while (lastBase < pulseCyc && cyc < pulseCyc + 20) tick();
    checkRange("ovr_slice0_latency", lastBase - pulseCyc, 1, 8);
    waitUntil(lastBase + 5);
    check("ovr_first_req", fetchReq, 1);
    check("ovr_first_idx", fetchIndex, 0);
    check("ovr_first_overrun", overrun, 0);
    waitUntil(lastBase + 12);
    check("ovr_second_req", fetchReq, 1);
    check("ovr_second_idx", fetchIndex, 1);
    check("ovr_second_overrun", overrun, 1);
    fetchAck = 1'b1;
    tick();
    check("ack_drops_req", fetchReq, 0);
    fetchAck = 1'b0;
    waitUntil(lastBase + 21);
    check("third_req", fetchReq, 1);
    check("third_idx", fetchIndex, 2);
    check("overrun_sticky", overrun, 1);

    // Reset mid-revolution discards the period
    nReset = 1'b0;
    expQ.delete();
    repeat (2) tick();
    check("midrst_period", period, 0);
    check("midrst_locked", locked, 0);
    check("midrst_fetchReq", fetchReq, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_sliceIndex", sliceIndex, 0);
    check("midrst_sliceStrobe", sliceStrobe, 0);
    nReset  = 1'b1;
    prevReq = 1'b0;
    repeat (3) tick();
    pulse();
    repeat (8) tick();
    check("post_rst_locked", locked, 0);
    check("post_rst_period", period, 0);
    repeat (200) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slice_scheduler.md
Name: slice_scheduler

Overview:
- Converts the once-per-revolution MAG2 magnet pulse into GLB_WIDTH evenly spaced column-slice strobes per revolution.
- Each strobe raises a column-fetch request, with handshake, to the LED column fetch/shift engine.
- Tracks rotor lock and flags two fault conditions: stalled rotor and fetch overrun.
- Sits between the MAG2 pin and the LED driver; runs entirely in the CLK_10M domain.

Parameters:
GLB_WIDTH, 128, slices per revolution; power of two.
PERIOD_W, 24, width of the revolution-period counter (cycles).
MIN_PERIOD, 333333, holdoff in cycles: MAG2 edges arriving sooner after the last accepted edge are ignored.
MAX_PERIOD, 2000000, timeout in cycles: no accepted edge within this count means the rotor is stalled.

Ports:
CLK_10M  in  1  system clock, 10 MHz
nReset  in  1  synchronous, active-low reset
MAG2  in  1  raw asynchronous magnet sensor, active-high pulse
sliceStrobe  out  1  one-cycle pulse at each slice boundary
sliceIndex  out  $clog2(GLB_WIDTH)  index of the current slice
fetchReq  out  1  column fetch request; level, held until acknowledged
fetchIndex  out  $clog2(GLB_WIDTH)  column to fetch; valid while fetchReq=1
fetchAck  in  1  fetch engine accepted the request
locked  out  1  a valid period has been measured and slices are running
stalled  out  1  sticky: timeout occurred; cleared by the next accepted edge
overrun  out  1  sticky: a strobe arrived while fetchReq was still pending; cleared only by reset
period  out  PERIOD_W  last measured revolution period, in cycles

Behaviour:
- Reset (nReset=0 at a clock edge):
  - All outputs go to 0, state goes to IDLE, all counters clear.
  - Reset applied mid-revolution discards the measured period.
- MAG2 front end:
  - Two-flop synchronizer, then rising-edge detect.
  - An edge is accepted only if cycSinceEdge >= MIN_PERIOD or the state is IDLE.
  - Fixed latency of 3 cycles from the first clock edge that samples MAG2 high to the internal acceptedEdge pulse.
- cycSinceEdge:
  - Resets to 0 on acceptedEdge; otherwise increments.
  - Saturates at MAX_PERIOD.
- States and transitions:
  - IDLE: wait. On acceptedEdge: clear cycSinceEdge, go to MEASURE.
  - MEASURE: on acceptedEdge, latch period=cycSinceEdge+1, set locked=1, clear stalled, go to RUN, and emit slice 0 in the same cycle.
  - RUN: slice k (1..GLB_WIDTH-1) strobes on the first cycle where t*GLB_WIDTH >= k*period, with t counting cycles since the slice-0 strobe.
    - Implementation: phaseAcc += GLB_WIDTH each cycle; compare against nextBound; on a hit, nextBound += period.
    - Width: PERIOD_W+$clog2(GLB_WIDTH) bits, so no wrap.
  - RUN, rotor sped up: on acceptedEdge, latch the new period and restart at slice 0 immediately. Unemitted slices are skipped.
  - RUN, rotor slowed down: after slice GLB_WIDTH-1 no further strobes occur. sliceIndex holds at GLB_WIDTH-1 until the next acceptedEdge.
  - Timeout: when cycSinceEdge reaches MAX_PERIOD in MEASURE or RUN, go to IDLE with locked=0, stalled=1, no strobes. period keeps its value.
- Simultaneous events:
  - acceptedEdge and a slice boundary in the same cycle: the edge wins; only a slice-0 strobe is emitted.
  - acceptedEdge and timeout in the same cycle: the edge wins.
- Outputs are registered. sliceStrobe and sliceIndex update in the same cycle.
- Fetch handshake:
  - On sliceStrobe with fetchReq=0: fetchReq<=1, fetchIndex<=sliceIndex.
  - fetchAck=1 while fetchReq=1: fetchReq<=0 on the next cycle.
  - fetchAck while fetchReq=0 is ignored.
  - Strobe while fetchReq=1 with no fetchAck that cycle: overrun<=1, fetchIndex<=newest index, fetchReq stays 1. The stale column is dropped.
  - Strobe and fetchAck in the same cycle: fetchReq stays 1, fetchIndex takes the new index, no overrun.
  - Leaving RUN due to timeout or reset: fetchReq is dropped to 0.

Decomposition:
- Package voxel_pkg:
  - GLB_WIDTH and GLB_FPS constants.
  - CLK_10M_FREQ=10000000.
  - typedef enum sched_state_t {IDLE, MEASURE, RUN}.
  - typedef slice_idx_t logic [$clog2(GLB_WIDTH)-1:0].
- One sub-module, mag_edge_sync: synchronizer, rising-edge detect and MIN_PERIOD holdoff. It outputs acceptedEdge.
- Slice timing and the fetch handshake stay in slice_scheduler.

Test Plan:
All scenarios use overrides MIN_PERIOD=100, MAX_PERIOD=5000, GLB_WIDTH=128.
1. MAG2 pulses 1280 cycles apart, fetchAck one cycle after each fetchReq -> second edge: locked=1, period=1280, slice 0 strobe; strobes then every 10 cycles, indices 0..127, no overrun.
2. period=1000 (non-integer slice spacing 7.8125) -> strobe k at offset ceil(k*1000/128): k=1 at 8, k=2 at 16, k=127 at 993; exactly 128 strobes.
3. Locked at 1280, next edge after 640 cycles -> strobe index 0 at that edge; slices 64..127 skipped; period=640.
4. Locked, then MAG2 held low -> 5000 cycles after the last edge: locked=0, stalled=1, fetchReq=0; the next two edges relock and clear stalled.
5. Glitch edge 50 cycles after an accepted edge -> ignored: period unchanged, no slice-0 restart.
6. fetchAck tied 0 -> first strobe sets fetchReq=1, fetchIndex=0; second strobe sets overrun=1, fetchIndex=1; asserting fetchAck drops fetchReq one cycle later.
